// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, ALUOp codes,
// sequencer states and instruction classes.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_ANDI  = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_ORI   = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU_R   = 3'd0,
    CL_SHIFT   = 3'd1,
    CL_ALU_I   = 3'd2,
    CL_LOAD    = 3'd3,
    CL_STORE   = 3'd4,
    CL_BRANCH  = 3'd5,
    CL_HALT    = 3'd6,
    CL_ILLEGAL = 3'd7
  } iclass_e;

endpackage

// File: rtl/cpu_main_decoder.sv
// Combinational main decoder: latched opcode to instruction class plus the
// ALUOp/ALUSrc pair used while the instruction is executing.
module cpu_main_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output iclass_e    iclass,
  output logic [1:0] alu_op,
  output logic       alu_src
);

  always_comb begin
    iclass  = CL_ILLEGAL;
    alu_op  = ALUOP_ADD;
    alu_src = 1'b0;
    case (op)
      OP_RTYPE: begin
        iclass = CL_ALU_R;
        alu_op = ALUOP_FUNCT;
      end
      OP_SHIFT: iclass = CL_SHIFT;
      OP_ADDI: begin
        iclass  = CL_ALU_I;
        alu_src = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        iclass  = CL_ALU_I;
        alu_op  = ALUOP_LOGIC;
        alu_src = 1'b1;
      end
      OP_LW: begin
        iclass  = CL_LOAD;
        alu_src = 1'b1;
      end
      OP_SW: begin
        iclass  = CL_STORE;
        alu_src = 1'b1;
      end
      OP_BEQ: begin
        iclass = CL_BRANCH;
        alu_op = ALUOP_SUB;
      end
      OP_HALT: iclass = CL_HALT;
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 16-bit CPU: one instruction phase per clock,
// wait-state memory handshake, sticky halt/illegal flags and a retire counter.
//
// state  | meaning
// FETCH  | IRWrite pulse, instruction register loads
// DECODE | opcode captured into op_q
// EXEC   | ALU operation per class; BEQ/illegal retire here
// MEM    | load/store strobe held until MemReady
// WB     | register write, EXEC controls held, PC advances
// HALT   | absorbing, all controls low until Reset
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [3:0]          opcode,
  input  logic                MemReady,
  output logic                RegDst,
  output logic                Branch,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                MemToReg,
  output logic                ALUSrc,
  output logic                Shift,
  output logic [1:0]          ALUOp,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                Halted,
  output logic                Illegal,
  output logic [RETIRE_W-1:0] Retired
);

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic                  halted_q, halted_d;
  logic                  illegal_q, illegal_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;

  iclass_e    iclass;
  logic [1:0] ex_alu_op;
  logic       ex_alu_src;

  logic reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg;
  logic alu_src, shift, pc_write, ir_write;
  logic [1:0] alu_op;

  cpu_main_decoder u_dec (
    .op      (op_q),
    .iclass  (iclass),
    .alu_op  (ex_alu_op),
    .alu_src (ex_alu_src)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    reg_dst    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    shift      = 1'b0;
    alu_op     = ALUOP_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_write = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        op_d = opcode;
        if (opcode == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op  = ex_alu_op;
        alu_src = ex_alu_src;
        case (iclass)
          CL_ALU_R, CL_ALU_I: state_d = ST_WB;
          CL_SHIFT: begin
            shift   = 1'b1;
            state_d = ST_WB;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_BRANCH: begin
            branch   = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
          CL_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            pc_write  = 1'b1;
            illegal_d = 1'b1;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        alu_src = 1'b1;
        alu_op  = ALUOP_ADD;
        if (iclass == CL_LOAD) begin
          mem_read = 1'b1;
          if (MemReady) state_d = ST_WB;
        end else begin
          mem_write = 1'b1;
          if (MemReady) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        // keep the EXEC-phase operands steering the ALU so write data is stable
        alu_op    = ex_alu_op;
        alu_src   = ex_alu_src;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_FETCH;
        case (iclass)
          CL_ALU_R: reg_dst = 1'b1;
          CL_LOAD:  mem_to_reg = 1'b1;
          CL_SHIFT: begin
            shift   = 1'b1;
            reg_dst = 1'b1;
          end
          default: reg_dst = 1'b0;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
    retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, pc_write};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_FETCH;
      op_q      <= 4'b0000;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // FETCH is the reset state, so the strobes are masked while Reset is held
  assign RegDst   = reg_dst    & ~Reset;
  assign Branch   = branch     & ~Reset;
  assign MemRead  = mem_read   & ~Reset;
  assign MemWrite = mem_write  & ~Reset;
  assign RegWrite = reg_write  & ~Reset;
  assign MemToReg = mem_to_reg & ~Reset;
  assign ALUSrc   = alu_src    & ~Reset;
  assign Shift    = shift      & ~Reset;
  assign ALUOp    = Reset ? 2'b00 : alu_op;
  assign PCWrite  = pc_write   & ~Reset;
  assign IRWrite  = ir_write   & ~Reset;
  assign Halted   = halted_q;
  assign Illegal  = illegal_q;
  assign Retired  = retired_q;

endmodule
